// File: rtl/priority_decoder_pkg.sv
// Shared types and helpers for the sequential 3-to-8 decoder.
// State encoding, counter width and the one-hot decode function.
package priority_decoder_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned LINE_W = 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [LINE_W-1:0] decode3to8(input logic [CODE_W-1:0] code);
    return 8'b1 << code;
  endfunction

endpackage

// File: rtl/priority_decoder_code_fifo.sv
// Small circular FIFO holding pending 3-bit codes; occupancy from wrap-bit pointers.
// The parent guarantees no push when full and no pop when empty.
module code_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= din;
  end

  assign head  = mem[rd_ptr_q[AW-1:0]];
  assign count = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/priority_decoder.sv
// Sequential 3-to-8 decoder: buffers codes and replays each as a one-hot pulse plus idle gap.
// Define PRIORITY_DECODER_ACK_EN to end pulses on out_ack instead of after PULSE_LEN cycles.
module priority_decoder
  import priority_decoder_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PULSE_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CODE_W-1:0]      datain,
  output logic [LINE_W-1:0]      dataout,
  output logic                   out_valid,
  input  logic                   out_ack,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("priority_decoder: DEPTH must be a power of two >= 2");
  end
  if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_pulse_len
    $error("priority_decoder: PULSE_LEN must be in 1..255");
  end

  state_t              state_q;
  state_t              state_d;
  logic [LINE_W-1:0]   dataout_d;
  logic                out_valid_d;
  logic                busy_d;
  logic                push;
  logic                pop;
  logic                drive_done;
  logic [CODE_W-1:0]   head;
  logic [LW-1:0]       fifo_count;
  logic [LW-1:0]       level_nxt;

  assign in_ready = (level < LW'(DEPTH));
  assign push     = in_valid && in_ready;

  code_fifo #(
    .DEPTH (DEPTH),
    .W     (CODE_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (datain),
    .head  (head),
    .count (fifo_count)
  );

`ifdef PRIORITY_DECODER_ACK_EN
  assign drive_done = out_ack;
`else
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             unused_ack;

  assign unused_ack = out_ack;

  // Pulse-width counter: loaded on pop, counts down while driving.
  always_comb begin
    cnt_d = cnt_q;
    if (pop) begin
      cnt_d = CNT_W'(PULSE_LEN - 1);
    end else if (state_q == DRIVE && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign drive_done = (cnt_q == '0);
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    dataout_d   = dataout;
    out_valid_d = out_valid;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_count != '0) begin
          pop         = 1'b1;
          dataout_d   = decode3to8(head);
          out_valid_d = 1'b1;
          state_d     = DRIVE;
        end
      end
      DRIVE: begin
        if (drive_done) begin
          dataout_d   = '0;
          out_valid_d = 1'b0;
          state_d     = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign level_nxt = fifo_count + LW'(push) - LW'(pop);
  assign busy_d    = (state_d != IDLE) || (level_nxt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dataout   <= '0;
      out_valid <= 1'b0;
      level     <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      dataout   <= dataout_d;
      out_valid <= out_valid_d;
      level     <= level_nxt;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_priority_decoder.sv
// Directed self-checking bench for priority_decoder (DEPTH=4, PULSE_LEN=4).
// Honours PRIORITY_DECODER_ACK_EN to exercise the acknowledge build.
module tb_priority_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] datain;
  logic [7:0] dataout;
  logic       out_valid;
  logic       out_ack;
  logic [2:0] level;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [2:0] codes    [8];
  logic [7:0] exp_data [8];
  int         pop_cyc  [8];
  int         last_accept_cyc;
  bit         full_seen;

  priority_decoder #(
    .DEPTH     (4),
    .PULSE_LEN (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .datain    (datain),
    .dataout   (dataout),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .level     (level),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Offers codes[0..n-1] in order, advancing only on an accepted handshake.
  task automatic drive_codes(input int n);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      in_valid = 1'b1;
      datain   = codes[i];
      while (!in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      check("accept_timeout", in_ready, 1);
      if (!in_ready) break;
      last_accept_cyc = cyc + 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    datain   = '0;
  endtask

  // Watches pulses for n_cyc cycles and compares them with exp_data[0..n_exp-1].
  task automatic monitor(input int n_exp, input int n_cyc, input bit hold_ack);
    logic       prev_v = 1'b0;
    logic [7:0] cur    = '0;
    int         width  = 0;
    int         idx    = 0;
    full_seen = 1'b0;
    out_ack   = hold_ack ? 1'b0 : 1'b1;
    for (int c = 0; c < n_cyc; c++) begin
      @(negedge clk);
      check("in_ready_vs_level", in_ready, (level < 3'd4));
      if (level == 3'd4) begin
        full_seen = 1'b1;
        out_ack   = 1'b1;
      end
      if (out_valid && !prev_v) begin
        check("pulse_code", dataout, (idx < n_exp) ? exp_data[idx] : 8'hff);
        if (idx < 8) pop_cyc[idx] = cyc;
        idx++;
        width = 1;
        cur   = dataout;
      end else if (out_valid) begin
        check("pulse_hold", dataout, cur);
        width++;
      end else if (prev_v) begin
        check("gap_zero", dataout, 8'h00);
`ifndef PRIORITY_DECODER_ACK_EN
        check("pulse_width", width, 4);
`endif
      end
      prev_v = out_valid;
    end
    check("pulse_count", idx, n_exp);
    check("end_level", level, 0);
    check("end_busy", busy, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    datain   = '0;
    out_ack  = 1'b0;
    last_accept_cyc = 0;

    repeat (2) @(negedge clk);
    check("rst_dataout", dataout, 8'h00);
    check("rst_out_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

`ifndef PRIORITY_DECODER_ACK_EN
    // Single code 5: pulse 8'h20 for four cycles, then a zero gap cycle.
    in_valid = 1'b1;
    datain   = 3'd5;
    @(negedge clk);
    in_valid = 1'b0;
    datain   = '0;
    check("single_level_after_push", level, 1);
    check("single_no_early_out", dataout, 8'h00);
    check("single_busy", busy, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("single_dataout", dataout, 8'h20);
      check("single_valid", out_valid, 1);
    end
    check("single_level_popped", level, 0);
    @(negedge clk);
    check("single_gap_data", dataout, 8'h00);
    check("single_gap_valid", out_valid, 0);
    check("single_gap_busy", busy, 1);
    @(negedge clk);
    check("single_idle_busy", busy, 0);
`else
    // Ack held in IDLE does nothing; then a pulse lasts until an ack is sampled.
    out_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("ack_idle_data", dataout, 8'h00);
    check("ack_idle_busy", busy, 0);
    out_ack  = 1'b0;
    in_valid = 1'b1;
    datain   = 3'd4;
    @(negedge clk);
    in_valid = 1'b0;
    datain   = '0;
    check("ack_no_early_out", dataout, 8'h00);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check("ack_dataout", dataout, 8'h10);
    end
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    check("ack_gap_data", dataout, 8'h00);
    check("ack_gap_valid", out_valid, 0);
    @(negedge clk);
    check("ack_idle_busy", busy, 0);
`endif

    // Backlog 7,0,0,2: order kept, repeated code gives two pulses.
    codes[0] = 3'd7; codes[1] = 3'd0; codes[2] = 3'd0; codes[3] = 3'd2;
    exp_data[0] = 8'h80; exp_data[1] = 8'h01; exp_data[2] = 8'h01; exp_data[3] = 8'h04;
    fork
      drive_codes(4);
      monitor(4, 40, 1'b0);
    join

    // Full FIFO: the last code waits until the first backlog pop frees a slot.
    codes[0] = 3'd6; codes[1] = 3'd1; codes[2] = 3'd2;
    codes[3] = 3'd3; codes[4] = 3'd4; codes[5] = 3'd5;
    exp_data[0] = 8'h40; exp_data[1] = 8'h02; exp_data[2] = 8'h04;
    exp_data[3] = 8'h08; exp_data[4] = 8'h10; exp_data[5] = 8'h20;
    fork
      drive_codes(6);
      monitor(6, 60, 1'b1);
    join
    check("full_reached", full_seen, 1);
    check("accept_after_pop", last_accept_cyc, pop_cyc[1] + 1);

    // Reset mid-pulse: outputs clear asynchronously and pending codes are lost.
    out_ack  = 1'b0;
    in_valid = 1'b1;
    datain   = 3'd3;
    @(negedge clk);
    datain   = 3'd4;
    @(negedge clk);
    in_valid = 1'b0;
    datain   = '0;
    check("midrst_driving", dataout, 8'h08);
    check("midrst_pending", level, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_dataout", dataout, 8'h00);
    check("midrst_valid", out_valid, 0);
    check("midrst_level", level, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    repeat (8) @(negedge clk);
    check("midrst_discarded", dataout, 8'h00);
    check("midrst_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
